alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
Parametrised, pipelined successor to the team's 4-bit-opcode combinational ALU. Operand width is configurable and there is a third operand c, as in the existing ALU. Results pass through a 2-stage registered pipeline with valid/ready handshakes on input and output, and each result carries status flags. A running accumulator register adds accumulate modes that the combinational block lacks.

Parameters:
WIDTH, 32, operand/result width in bits (>=8, power of 2)
SHW, $clog2(WIDTH), shift-amount width taken from b[SHW-1:0]

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand/opcode bundle valid
in_ready  output  1  block can accept bundle this cycle
ctrl  input  4  opcode
a  input  WIDTH  operand A
b  input  WIDTH  operand B
c  input  WIDTH  operand C
out_valid  output  1  d/flags valid
out_ready  input  1  downstream accepts result
d  output  WIDTH  result
flag_z  output  1  d == 0
flag_n  output  1  d[WIDTH-1]
flag_c  output  1  carry (ADD/ADD3) or borrow (SUB), else 0
flag_v  output  1  signed overflow (ADD/SUB), else 0

Behaviour:
- Reset (async, rst_n=0):
  - s1_valid=0, s2_valid=0, out_valid=0.
  - d=0, all flags=0, acc=0.
  - in_ready=1 from the first clock after reset release.
- Transfers: input when in_valid&&in_ready; output when out_valid&&out_ready.
- Stage 1 registers ctrl/a/b/c and s1_valid.
- Stage 2 computes the result from stage 1 and registers d, flags and s2_valid (out_valid=s2_valid).
- Advance rules:
  - s2_load = s1_valid && (!s2_valid || out_ready).
  - s1_load = in_valid && in_ready.
  - in_ready = !s1_valid || s2_load. Combinational through out_ready; no combinational path from in_valid to in_ready.
- Latency: exactly 2 cycles from input transfer to out_valid when out_ready=1. Throughput is 1 bundle/cycle.
- Backpressure:
  - With out_ready=0, the pipe holds 2 bundles, then in_ready=0.
  - d and flags stay stable while out_valid&&!out_ready.
  - No bundle is lost or duplicated.
- Opcodes (all arithmetic mod 2^WIDTH):
  - 0000 ADD a+b
  - 0001 SUB a-b
  - 0010 MUL low WIDTH bits of a*b
  - 0011 MAC low of a*b+c
  - 0100 AND
  - 0101 OR
  - 0110 XOR
  - 0111 NOT a
  - 1000 SHL a<<b[SHW-1:0]
  - 1001 SHR logical
  - 1010 SRA arithmetic
  - 1011 SLT signed a<b ? 1:0
  - 1100 SLTU unsigned a<b ? 1:0
  - 1101 ADD3 a+b+c
  - 1110 ACC_CLR: acc<=0, d=0
  - 1111 ACC_ADD: acc<=acc+a, d=new acc value
- Flag rules:
  - flag_c: ADD = carry out of bit WIDTH-1. SUB = 1 iff a<b unsigned. ADD3 = 1 iff the true sum ≥ 2^WIDTH.
  - flag_v: ADD/SUB standard two's-complement overflow.
  - flag_z and flag_n apply to every opcode.
- Accumulator:
  - acc updates only on s2_load of opcode 1110/1111. It does not update while stalled.
  - Back-to-back ACC_ADD each see the previous result (no hazard).
  - acc wraps mod 2^WIDTH; flag_c is not set for accumulator ops.
- Shift amounts ≥ WIDTH are impossible by construction (b truncated to SHW bits).
- Reset mid-operation clears both stages and acc immediately; in-flight bundles are discarded and no out_valid pulse follows.

Test Plan:
- WIDTH=32, a=15 b=20 c=35, each opcode 0000..1101 streamed back-to-back with out_ready=1. Required results in order, each 2 cycles after its input:
  - 35, 0xFFFFFFFB (n=1 c=1), 300, 335
  - 4, 31, 27, 0xFFFFFFF0
  - 15<<20=0x00F00000, 0, 0
  - SLT=1, SLTU=1, 70
- Overflow: ADD a=0x7FFFFFFF b=1 -> d=0x80000000 v=1 n=1 c=0. ADD a=0xFFFFFFFF b=1 -> d=0 z=1 c=1 v=0.
- Backpressure:
  - Hold out_ready=0, offer 4 ADD bundles (a=1..4, b=0): in_ready drops after 2 accepted, and d=1 stays stable.
  - Release out_ready: outputs are 1,2,3,4 in order with no gaps, duplicates or losses.
- Accumulator: ACC_CLR, then ACC_ADD a=5, a=7, a=0xFFFFFFFF back-to-back -> d=0,5,12,11.
- Accumulator under stall: ACC_ADD stream with random out_ready stalls; the final acc equals the software sum.
- Async reset: assert rst_n=0 mid-cycle with both stages full. out_valid, d, flags and acc go to 0 immediately. After release, no stale result appears, and a following ACC_ADD a=3 gives d=3.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with a valid/ready handshake on both
// sides. It produces status flags for every result and keeps a running
// accumulator.
//
// Ports
//   clk, rst_n           clock; asynchronous active-low reset
//   in_valid / in_ready  input handshake for the bundle {ctrl, a, b, c}
//   ctrl                 4-bit opcode
//   a, b, c              WIDTH-bit operands
//   out_valid/out_ready  output handshake for the bundle {d, flags}
//   d                    WIDTH-bit result
//   flag_z/n/c/v         zero, negative, carry/borrow, signed overflow
module alu_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam logic [3:0] OP_ADD     = 4'b0000;
  localparam logic [3:0] OP_SUB     = 4'b0001;
  localparam logic [3:0] OP_MUL     = 4'b0010;
  localparam logic [3:0] OP_MAC     = 4'b0011;
  localparam logic [3:0] OP_AND     = 4'b0100;
  localparam logic [3:0] OP_OR      = 4'b0101;
  localparam logic [3:0] OP_XOR     = 4'b0110;
  localparam logic [3:0] OP_NOT     = 4'b0111;
  localparam logic [3:0] OP_SHL     = 4'b1000;
  localparam logic [3:0] OP_SHR     = 4'b1001;
  localparam logic [3:0] OP_SRA     = 4'b1010;
  localparam logic [3:0] OP_SLT     = 4'b1011;
  localparam logic [3:0] OP_SLTU    = 4'b1100;
  localparam logic [3:0] OP_ADD3    = 4'b1101;
  localparam logic [3:0] OP_ACC_CLR = 4'b1110;
  localparam logic [3:0] OP_ACC_ADD = 4'b1111;

  // Stage 1 holds the captured operand bundle.
  logic             s1_valid;
  logic [3:0]       s1_ctrl;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [WIDTH-1:0] s1_c;

  logic             s2_valid;
  logic [WIDTH-1:0] acc;

  logic             s1_load;
  logic             s2_load;

  // Datapath intermediates, one extra bit (two for ADD3) to expose carries.
  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH+1:0] add3_w;
  logic [WIDTH-1:0] acc_sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] res;
  logic             res_c;
  logic             res_v;

  // Handshake control. in_ready depends on out_ready but never on in_valid.
  assign s2_load   = s1_valid && (!s2_valid || out_ready);
  assign in_ready  = !s1_valid || s2_load;
  assign s1_load   = in_valid && in_ready;
  assign out_valid = s2_valid;

  assign add_w   = {1'b0, s1_a} + {1'b0, s1_b};
  assign sub_w   = {1'b0, s1_a} - {1'b0, s1_b};
  assign add3_w  = {2'b00, s1_a} + {2'b00, s1_b} + {2'b00, s1_c};
  assign acc_sum = acc + s1_a;
  assign shamt   = s1_b[SHW-1:0];

  // Result and carry/overflow selection for the opcode held in stage 1.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (s1_ctrl)
      OP_ADD: begin
        res   = add_w[WIDTH-1:0];
        res_c = add_w[WIDTH];
        res_v = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) && (add_w[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_SUB: begin
        res   = sub_w[WIDTH-1:0];
        res_c = sub_w[WIDTH];
        res_v = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) && (sub_w[WIDTH-1] != s1_a[WIDTH-1]);
      end
      OP_MUL:     res = s1_a * s1_b;
      OP_MAC:     res = s1_a * s1_b + s1_c;
      OP_AND:     res = s1_a & s1_b;
      OP_OR:      res = s1_a | s1_b;
      OP_XOR:     res = s1_a ^ s1_b;
      OP_NOT:     res = ~s1_a;
      OP_SHL:     res = s1_a << shamt;
      OP_SHR:     res = s1_a >> shamt;
      OP_SRA:     res = WIDTH'($signed(s1_a) >>> shamt);
      OP_SLT:     res = {{(WIDTH-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
      OP_SLTU:    res = {{(WIDTH-1){1'b0}}, (s1_a < s1_b)};
      OP_ADD3: begin
        res   = add3_w[WIDTH-1:0];
        res_c = |add3_w[WIDTH+1:WIDTH];
      end
      OP_ACC_CLR: res = '0;
      OP_ACC_ADD: res = acc_sum;
      default:    res = '0;
    endcase
  end

  // Stage 1: operand capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ctrl  <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_ctrl  <= ctrl;
        s1_a     <= a;
        s1_b     <= b;
        s1_c     <= c;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // Stage 2: result and flag registers. They hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      d        <= '0;
      flag_z   <= 1'b0;
      flag_n   <= 1'b0;
      flag_c   <= 1'b0;
      flag_v   <= 1'b0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        d        <= res;
        flag_z   <= (res == '0);
        flag_n   <= res[WIDTH-1];
        flag_c   <= res_c;
        flag_v   <= res_v;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  // The accumulator commits with its bundle, so back-to-back ACC_ADDs chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (s2_load) begin
      if (s1_ctrl == OP_ACC_CLR) begin
        acc <= '0;
      end else if (s1_ctrl == OP_ACC_ADD) begin
        acc <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=32).
module tb_alu_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned NA = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   ctrl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] c;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] d;
  logic         flag_z;
  logic         flag_n;
  logic         flag_c;
  logic         flag_v;

  int tests;
  int fails;

  logic [W-1:0] op_d   [14];
  logic [3:0]   op_f   [14];
  logic [W-1:0] acc_d  [4];
  logic [W-1:0] vals   [NA+1];
  logic [W-1:0] psum   [NA+1];
  int           sent;
  int           got;
  int           cyc;
  logic         in_fire;
  logic         out_fire;
  logic [W-1:0] obs_d;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ctrl      (ctrl),
    .a         (a),
    .b         (b),
    .c         (c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [W-1:0] xa,
                       input logic [W-1:0] xb, input logic [W-1:0] xc);
    in_valid = v;
    ctrl     = op;
    a        = xa;
    b        = xb;
    c        = xc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] flags();
    return 64'({flag_z, flag_n, flag_c, flag_v});
  endfunction

  initial begin
    tests = 0;
    fails = 0;
    op_d  = '{32'd35, 32'hFFFFFFFB, 32'd300, 32'd335, 32'd4, 32'd31, 32'd27,
              32'hFFFFFFF0, 32'h00F00000, 32'd0, 32'd0, 32'd1, 32'd1, 32'd70};
    // {z,n,c,v}
    op_f  = '{4'b0000, 4'b0110, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
              4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
    acc_d = '{32'd0, 32'd5, 32'd12, 32'd11};

    // Reset state
    rst_n     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 4'd0, '0, '0, '0);
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_d", 64'(d), 64'd0);
    check("rst_flags", flags(), 64'd0);
    check("rst_acc", 64'(dut.acc), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // All non-accumulator opcodes streamed back-to-back
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, 4'(i), 32'd15, 32'd20, 32'd35);
      tick();
      if (i > 0) begin
        check("op_valid", 64'(out_valid), 64'd1);
        check($sformatf("op%0d_d", i - 1), 64'(d), 64'(op_d[i-1]));
        check($sformatf("op%0d_flags", i - 1), flags(), 64'(op_f[i-1]));
      end
    end
    drive(1'b0, 4'd0, '0, '0, '0);
    tick();
    check("op13_d", 64'(d), 64'(op_d[13]));
    check("op13_flags", flags(), 64'(op_f[13]));
    tick();
    check("op_drain_valid", 64'(out_valid), 64'd0);

    // Carry and overflow corners
    drive(1'b1, 4'b0000, 32'h7FFFFFFF, 32'd1, '0);
    tick();
    drive(1'b1, 4'b0000, 32'hFFFFFFFF, 32'd1, '0);
    tick();
    check("ovf_add_d", 64'(d), 64'h80000000);
    check("ovf_add_flags", flags(), 64'b0101);
    drive(1'b1, 4'b0001, 32'h80000000, 32'd1, '0);
    tick();
    check("wrap_add_d", 64'(d), 64'd0);
    check("wrap_add_flags", flags(), 64'b1010);
    drive(1'b0, 4'd0, '0, '0, '0);
    tick();
    check("ovf_sub_d", 64'(d), 64'h7FFFFFFF);
    check("ovf_sub_flags", flags(), 64'b0001);
    tick();

    // Backpressure: two bundles fill the pipe, then in_ready drops
    out_ready = 1'b0;
    drive(1'b1, 4'b0000, 32'd1, '0, '0);
    #1;
    check("bp_ready0", 64'(in_ready), 64'd1);
    tick();
    drive(1'b1, 4'b0000, 32'd2, '0, '0);
    #1;
    check("bp_ready1", 64'(in_ready), 64'd1);
    tick();
    check("bp_valid1", 64'(out_valid), 64'd1);
    check("bp_d1", 64'(d), 64'd1);
    drive(1'b1, 4'b0000, 32'd3, '0, '0);
    #1;
    check("bp_full_ready", 64'(in_ready), 64'd0);
    tick();
    check("bp_hold_d_a", 64'(d), 64'd1);
    check("bp_hold_ready", 64'(in_ready), 64'd0);
    tick();
    check("bp_hold_d_b", 64'(d), 64'd1);
    check("bp_hold_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    check("bp_d2", 64'(d), 64'd2);
    drive(1'b1, 4'b0000, 32'd4, '0, '0);
    tick();
    check("bp_d3", 64'(d), 64'd3);
    check("bp_v3", 64'(out_valid), 64'd1);
    drive(1'b0, 4'd0, '0, '0, '0);
    tick();
    check("bp_d4", 64'(d), 64'd4);
    check("bp_v4", 64'(out_valid), 64'd1);
    tick();
    check("bp_empty", 64'(out_valid), 64'd0);

    // Accumulator back-to-back chaining with wrap
    for (int i = 0; i < 4; i++) begin
      case (i)
        0:       drive(1'b1, 4'b1110, '0, '0, '0);
        1:       drive(1'b1, 4'b1111, 32'd5, '0, '0);
        2:       drive(1'b1, 4'b1111, 32'd7, '0, '0);
        default: drive(1'b1, 4'b1111, 32'hFFFFFFFF, '0, '0);
      endcase
      tick();
      if (i > 0) begin
        check($sformatf("acc%0d_d", i - 1), 64'(d), 64'(acc_d[i-1]));
        check($sformatf("acc%0d_c", i - 1), 64'(flag_c), 64'd0);
      end
    end
    drive(1'b0, 4'd0, '0, '0, '0);
    tick();
    check("acc3_d", 64'(d), 64'(acc_d[3]));
    check("acc3_c", 64'(flag_c), 64'd0);
    tick();

    // Accumulator under random output stalls
    vals[0] = '0;
    psum[0] = '0;
    for (int i = 1; i <= NA; i++) begin
      vals[i] = $urandom();
      psum[i] = psum[i-1] + vals[i];
    end
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < NA + 1 && cyc < 400) begin
      out_ready = 1'($urandom_range(0, 1));
      if (sent == 0)            drive(1'b1, 4'b1110, '0, '0, '0);
      else if (sent <= NA)      drive(1'b1, 4'b1111, vals[sent], '0, '0);
      else                      drive(1'b0, 4'd0, '0, '0, '0);
      #1;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      obs_d    = d;
      tick();
      if (in_fire) sent++;
      if (out_fire) begin
        check($sformatf("stall_d%0d", got), 64'(obs_d), 64'(psum[got]));
        got++;
      end
      cyc++;
    end
    check("stall_count", 64'(got), 64'(NA + 1));
    check("stall_acc", 64'(dut.acc), 64'(psum[NA]));

    // Asynchronous reset with both stages full
    out_ready = 1'b0;
    drive(1'b1, 4'b1111, 32'd9, '0, '0);
    tick();
    tick();
    drive(1'b0, 4'd0, '0, '0, '0);
    check("prerst_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_d", 64'(d), 64'd0);
    check("arst_flags", flags(), 64'd0);
    check("arst_acc", 64'(dut.acc), 64'd0);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_stale", 64'(out_valid), 64'd0);
    end
    drive(1'b1, 4'b1111, 32'd3, '0, '0);
    tick();
    drive(1'b0, 4'd0, '0, '0, '0);
    tick();
    check("post_rst_acc_valid", 64'(out_valid), 64'd1);
    check("post_rst_acc_d", 64'(d), 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
